// File: rtl/ibex_ahb_arbiter.sv
// ibex_ahb_arbiter: shares one AHB-Lite master between the Ibex fetch and LSU ports. Rev 1.0
// Optional macro IBEX_AHB_ARB_ERR_EN adds instr_err_o/data_err_o and honours HRESP.
`default_nettype none

module ibex_ahb_arbiter #(
  parameter bit          DATA_PRIO  = 1'b1,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
`ifdef IBEX_AHB_ARB_ERR_EN
  output logic        instr_err_o,
  output logic        data_err_o,
`endif
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] OWN_NONE      = 2'd0;
  localparam logic [1:0] OWN_INSTR     = 2'd1;
  localparam logic [1:0] OWN_DATA      = 2'd2;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [1:0]  owner_q, owner_d;
  logic        lock_q, lock_d;
  logic        lock_data_q, lock_data_d;
  logic        prio_data_q, prio_data_d;
  logic [31:0] hwdata_q, hwdata_d;

  logic        sel_data;
  logic        any_req;
  logic        nonseq;
  logic        gnt;
  logic        err_stall;
  logic [2:0]  data_size;
  logic [1:0]  data_off;
  logic [3:0]  unused_addr_lsb;

  assign unused_addr_lsb = {instr_addr_i[1:0], data_addr_i[1:0]};

`ifdef IBEX_AHB_ARB_ERR_EN
  // First error cycle: the address phase must be withdrawn.
  assign err_stall = HRESP & ~HREADY;
`else
  logic unused_hresp;
  assign unused_hresp = HRESP;
  assign err_stall    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q     <= OWN_NONE;
      lock_q      <= 1'b0;
      lock_data_q <= 1'b0;
      prio_data_q <= 1'b0;
      hwdata_q    <= 32'h0;
    end else begin
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      lock_data_q <= lock_data_d;
      prio_data_q <= prio_data_d;
      hwdata_q    <= hwdata_d;
    end
  end

  // A latched winner keeps the address phase until HREADY accepts it.
  always_comb begin
    sel_data = 1'b0;
    any_req  = 1'b0;
    if (lock_q) begin
      sel_data = lock_data_q;
      any_req  = 1'b1;
    end else begin
      any_req = instr_req_i | data_req_i;
      if (instr_req_i && data_req_i) begin
        sel_data = (DATA_PRIO != 1'b0) ? 1'b1 : prio_data_q;
      end else begin
        sel_data = data_req_i;
      end
    end
  end

  assign nonseq = any_req & rst_ni & ~err_stall;
  assign gnt    = nonseq & HREADY;

  always_comb begin
    owner_d     = owner_q;
    lock_d      = lock_q;
    lock_data_d = lock_data_q;
    prio_data_d = prio_data_q;
    hwdata_d    = hwdata_q;
    if ((owner_q != OWN_NONE) && HREADY) begin
      owner_d = OWN_NONE;
    end
    if (gnt) begin
      owner_d     = sel_data ? OWN_DATA : OWN_INSTR;
      lock_d      = 1'b0;
      prio_data_d = ~sel_data;
      if (sel_data) begin
        hwdata_d = data_wdata_i;
      end
    end else if (nonseq && !HREADY) begin
      lock_d      = 1'b1;
      lock_data_d = sel_data;
    end
  end

  always_comb begin
    data_size = 3'b010;
    data_off  = 2'b00;
    case (data_be_i)
      4'b0011: begin data_size = 3'b001; data_off = 2'b00; end
      4'b1100: begin data_size = 3'b001; data_off = 2'b10; end
      4'b0001: begin data_size = 3'b000; data_off = 2'b00; end
      4'b0010: begin data_size = 3'b000; data_off = 2'b01; end
      4'b0100: begin data_size = 3'b000; data_off = 2'b10; end
      4'b1000: begin data_size = 3'b000; data_off = 2'b11; end
      default: begin data_size = 3'b010; data_off = 2'b00; end
    endcase
  end

  always_comb begin
    HTRANS = nonseq ? HTRANS_NONSEQ : HTRANS_IDLE;
    HBURST = 3'b000;
    HWDATA = hwdata_q;
    if (nonseq && sel_data) begin
      HADDR  = {data_addr_i[31:2], data_off};
      HSIZE  = data_size;
      HWRITE = data_we_i;
    end else if (nonseq) begin
      HADDR  = {instr_addr_i[31:2], 2'b00};
      HSIZE  = 3'b010;
      HWRITE = 1'b0;
    end else begin
      HADDR  = RESET_ADDR;
      HSIZE  = 3'b010;
      HWRITE = 1'b0;
    end
    instr_gnt_o    = gnt & ~sel_data;
    data_gnt_o     = gnt & sel_data;
    // Gating with rst_ni drops the data phase abandoned by a reset.
    instr_rvalid_o = rst_ni & HREADY & (owner_q == OWN_INSTR);
    data_rvalid_o  = rst_ni & HREADY & (owner_q == OWN_DATA);
    instr_rdata_o  = HRDATA;
    data_rdata_o   = HRDATA;
  end

`ifdef IBEX_AHB_ARB_ERR_EN
  assign instr_err_o = instr_rvalid_o & HRESP;
  assign data_err_o  = data_rvalid_o & HRESP;
`endif

endmodule

`default_nettype wire

// File: doc/ibex_ahb_arbiter.md
Name: ibex_ahb_arbiter

Overview:
Shares one AHB-Lite master port between the Ibex instruction-fetch and data (LSU) interfaces. Selects one requester per address phase and drives the AHB address and control signals. It tracks which requester owns the pending data phase and routes HRDATA/HREADY back to that requester as rvalid/rdata. It sits between the core and the AHB interconnect, in the place of the plain bridge.

Parameters:
DATA_PRIO, 1, 1 = data port always wins a tie; 0 = round-robin between instr and data.
RESET_ADDR, 32'h0, HADDR value driven while idle and in reset.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous active-low reset
instr_req_i  in  1  fetch request; held with instr_addr_i until granted
instr_addr_i  in  32  fetch address, word aligned
instr_gnt_o  out  1  fetch address phase accepted
instr_rvalid_o  out  1  fetch data valid
instr_rdata_o  out  32  fetch data
data_req_i  in  1  LSU request
data_we_i  in  1  1 = write
data_be_i  in  4  byte enables
data_addr_i  in  32  LSU address; [1:0] ignored
data_wdata_i  in  32  write data
data_gnt_o  out  1  LSU address phase accepted
data_rvalid_o  out  1  LSU data phase complete
data_rdata_o  out  32  LSU read data
HADDR  out  32  AHB address
HTRANS  out  2  IDLE=00 / NONSEQ=10 only
HSIZE  out  3  transfer size
HBURST  out  3  always SINGLE (000)
HWRITE  out  1  write flag
HWDATA  out  32  write data, valid in the data phase
HRDATA  in  32  read data
HREADY  in  1  transfer done / stall
HRESP  in  1  slave error

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - HTRANS=00, HADDR=RESET_ADDR, HWRITE=0, HSIZE=010, HWDATA=0.
  - All gnt_o and rvalid_o are 0; owner register = NONE; round-robin pointer = instr.
  - A reset mid-transfer abandons the pending data phase: no rvalid is ever issued for it.
- Arbitration (combinational), evaluated when no address phase is locked:
  - DATA_PRIO=1: data beats instr.
  - DATA_PRIO=0: on a tie, the port that did not win last grant wins; the pointer updates on each grant.
- Address phase:
  - Any request present → HTRANS=NONSEQ, and address/control come from the winner.
  - No request → HTRANS=IDLE.
- Grant: winner's gnt_o=1 in the cycle HTRANS=NONSEQ and HREADY=1 (zero-latency grant). Otherwise gnt_o=0.
- Lock: if NONSEQ is driven with HREADY=0, the winner is latched. HADDR/HWRITE/HSIZE stay stable until HREADY=1, even if the other port raises req.
- HSIZE/HADDR[1:0]:
  - instr: always 010, offset 00.
  - data, be=1111: 010, offset 00.
  - data, be=0011: 001, offset 00. be=1100: 001, offset 10.
  - data, single bit set: 000, offset = index of that bit.
  - data, any other pattern: 010, offset 00.
- Data phase:
  - On grant, the owner register is set to the winner and data_wdata_i is registered into HWDATA.
  - The data phase completes on the first subsequent cycle with HREADY=1. In that cycle the owner's rvalid_o=1 (writes too) and rdata_o=HRDATA.
  - rdata_o of the non-owner is don't-care (driven HRDATA).
- Pipelining: a new grant may occur in the same cycle a data phase completes, giving back-to-back transfers at 1 per cycle with HREADY=1.
- Simultaneous events: a grant and an rvalid to the same port in one cycle are legal.
- Latency: read granted at cycle N with zero-wait slave → rvalid at N+1.

Optional Feature:
IBEX_AHB_ARB_ERR_EN:
- Defined:
  - Adds outputs instr_err_o and data_err_o (1 bit each).
  - On HRESP=1 with HREADY=0 (first error cycle), HTRANS is forced to IDLE and no grant is given.
  - On HRESP=1 with HREADY=1 (second cycle), the owner gets rvalid_o=1 and err_o=1.
  - err_o is 0 in every other cycle and in reset.
- Undefined: err ports are absent and HRESP is ignored.

Test Plan:
- Single fetch: instr_req, addr 0x4, HREADY=1 → same cycle instr_gnt=1, HADDR=0x4, HTRANS=10, HSIZE=010. Next cycle: instr_rvalid=1, instr_rdata=HRDATA.
- Tie with DATA_PRIO=1 (instr 0x4, data read 0x6, be=1100): data granted first with HADDR=0x6, HSIZE=001; instr granted next cycle. With DATA_PRIO=0 over 4 repeated ties, grants alternate instr/data.
- Wait states: data write be=0001 addr 0x10, HREADY low 2 cycles → HADDR=0x10, HSIZE=000 stable. instr_req raised meanwhile is not granted. HWDATA held. data_rvalid is asserted on the HREADY=1 cycle.
- Back-to-back: 3 fetches with HREADY=1 → 3 consecutive gnt cycles, then 3 consecutive rvalid cycles offset by 1.
- Reset mid-transfer: grant at cycle N, rst_ni=0 at N+1 → HTRANS=00 at the next edge and no rvalid afterward.
- ERR_EN: data read gets HRESP=1/HREADY=0 then HRESP=1/HREADY=1 → HTRANS=IDLE during the first cycle; data_rvalid=1 and data_err=1 in the second.
